// File: rtl/ineq_pkg.sv
// ---------------------------------------------------------------------------
// ineq_pkg
// Shared definitions for the Inequality self-test scanner.
//   - state_t    : scanner FSM states (idle, apply, sample, done)
//   - NUM_W      : width of the stimulus NUM bus
//   - OUT_W      : width of the OUT result bus
//   - VEC_COUNT  : number of stimulus vectors (all NUM values)
//   - ERR_W      : width of the error counter (must hold VEC_COUNT)
//   - INEQ_EXP2/1/0 : default golden truth tables, bit n = expected OUT[k]
//                     when NUM = n
// ---------------------------------------------------------------------------
package ineq_pkg;

    localparam int NUM_W     = 4;
    localparam int OUT_W     = 3;
    localparam int VEC_COUNT = 16;
    localparam int ERR_W     = 5;

    localparam logic [VEC_COUNT-1:0] INEQ_EXP2 = 16'hFF00;
    localparam logic [VEC_COUNT-1:0] INEQ_EXP1 = 16'h5555;
    localparam logic [VEC_COUNT-1:0] INEQ_EXP0 = 16'h0007;

    // Literals carry an ST_ prefix so they never collide with same-named
    // ports (DONE) in modules that import this package.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ineq_settle_timer.sv
// ---------------------------------------------------------------------------
// ineq_settle_timer
// Loadable down-counter. Loading with N (N >= 1) makes 'expired' assert
// after the counter has been enabled for N cycles, i.e. a holder that waits
// on 'expired' stays put for exactly N cycles including the load cycle's
// successor.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset (counter -> 0)
//   load       : load the counter with load_value-1
//   load_value : number of cycles to wait (1..2**CNT_W-1)
//   enable     : count down while high
//   expired    : high when the count has reached zero
// ---------------------------------------------------------------------------
module ineq_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Loading with value-1 lets the first held cycle count as one of the N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value - 1'b1;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/inequality_scanner.sv
// ---------------------------------------------------------------------------
// inequality_scanner
// In-system stimulus driver and checker for the combinational Inequality
// block. On START it steps NUM through 0..15, holds each value for SETTLE
// cycles, samples OUT for one cycle and compares it against the golden
// truth tables EXP2/EXP1/EXP0.
// Optional build macro: INEQ_FAIL_MASK_EN adds the FAIL_MASK output.
// Ports:
//   CLK             : rising-edge clock
//   RESET           : asynchronous active-high reset
//   START           : begin a scan (honoured only in idle or done)
//   OUT             : result from the Inequality instance under test
//   NUM             : registered stimulus to the Inequality instance
//   BUSY            : scan in progress (apply or sample)
//   DONE            : scan finished, results valid
//   PASS            : done with zero mismatching vectors
//   ERR_COUNT       : number of mismatching vectors (0..16)
//   FIRST_FAIL_NUM  : NUM of the first mismatching vector, 0 if none
//   FIRST_FAIL_BITS : OUT xor expected at the first failure, 0 if none
//   FAIL_MASK       : (INEQ_FAIL_MASK_EN only) bit n set if vector n failed
// ---------------------------------------------------------------------------
module inequality_scanner
    import ineq_pkg::*;
#(
    parameter int                   SETTLE = 1,
    parameter logic [VEC_COUNT-1:0] EXP2   = INEQ_EXP2,
    parameter logic [VEC_COUNT-1:0] EXP1   = INEQ_EXP1,
    parameter logic [VEC_COUNT-1:0] EXP0   = INEQ_EXP0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [OUT_W-1:0] OUT,
    output logic [NUM_W-1:0] NUM,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic [NUM_W-1:0] FIRST_FAIL_NUM,
    output logic [OUT_W-1:0] FIRST_FAIL_BITS
`ifdef INEQ_FAIL_MASK_EN
    ,
    output logic [VEC_COUNT-1:0] FAIL_MASK
`else
    // Default build: no per-vector failure mask port.
`endif
);

    localparam logic [NUM_W-1:0] LAST_NUM = NUM_W'(VEC_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(VEC_COUNT);
    localparam logic [3:0]       SETTLE_V = 4'(SETTLE);

    state_t           state;
    state_t           next_state;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expired;
    logic             scan_start;
    logic             do_sample;
    logic             first_seen;
    logic [OUT_W-1:0] expected_bits;
    logic [OUT_W-1:0] mism;

    ineq_settle_timer #(
        .CNT_W (4)
    ) u_settle (
        .clk        (CLK),
        .rst        (RESET),
        .load       (timer_load),
        .load_value (SETTLE_V),
        .enable     (timer_en),
        .expired    (timer_expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes. The timer is reloaded on every entry
    // to apply, so each vector gets a fresh SETTLE-cycle hold.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        scan_start = 1'b0;
        do_sample  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    next_state = ST_APPLY;
                    timer_load = 1'b1;
                    scan_start = 1'b1;
                end
            end
            ST_APPLY: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                do_sample = 1'b1;
                if (NUM == LAST_NUM) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_APPLY;
                    timer_load = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Golden lookup for the vector currently on NUM.
    always_comb begin
        expected_bits = {EXP2[NUM], EXP1[NUM], EXP0[NUM]};
        mism          = OUT ^ expected_bits;
    end

    // Scan datapath: stimulus, error count, first-failure capture and the
    // registered pass flag, which only becomes true on entry to done.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            NUM             <= '0;
            PASS            <= 1'b0;
            ERR_COUNT       <= '0;
            FIRST_FAIL_NUM  <= '0;
            FIRST_FAIL_BITS <= '0;
            first_seen      <= 1'b0;
        end else if (scan_start) begin
            NUM             <= '0;
            PASS            <= 1'b0;
            ERR_COUNT       <= '0;
            FIRST_FAIL_NUM  <= '0;
            FIRST_FAIL_BITS <= '0;
            first_seen      <= 1'b0;
        end else if (do_sample) begin
            if (mism != '0) begin
                if (ERR_COUNT != ERR_MAX) begin
                    ERR_COUNT <= ERR_COUNT + 1'b1;
                end
                if (!first_seen) begin
                    first_seen      <= 1'b1;
                    FIRST_FAIL_NUM  <= NUM;
                    FIRST_FAIL_BITS <= mism;
                end
            end
            if (NUM == LAST_NUM) begin
                PASS <= (ERR_COUNT == '0) && (mism == '0);
            end else begin
                NUM <= NUM + 1'b1;
            end
        end
    end

`ifdef INEQ_FAIL_MASK_EN
    // Per-vector failure map, cleared on each new scan.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FAIL_MASK <= '0;
        end else if (scan_start) begin
            FAIL_MASK <= '0;
        end else if (do_sample && (mism != '0)) begin
            FAIL_MASK[NUM] <= 1'b1;
        end
    end
`endif

    assign BUSY = (state == ST_APPLY) || (state == ST_SAMPLE);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_inequality_scanner.sv
// ---------------------------------------------------------------------------
// tb_inequality_scanner
// Directed self-checking bench for inequality_scanner (SETTLE = 1). A
// behavioural Inequality model drives OUT, with an optional stuck-at-1
// fault on OUT[0]. Each scan's expected result is predicted from the model
// and the golden tables when the scan is started, queued, and popped when
// DONE appears.
// ---------------------------------------------------------------------------
module tb_inequality_scanner;

    localparam int          SETTLE      = 1;
    localparam int          SCAN_EDGES  = 16 * (SETTLE + 1);
    localparam int          WAIT_BUDGET = 200;
    localparam logic [15:0] GOLD2       = 16'hFF00;
    localparam logic [15:0] GOLD1       = 16'h5555;
    localparam logic [15:0] GOLD0       = 16'h0007;

    typedef struct {
        logic        pass;
        logic [4:0]  errCount;
        logic [3:0]  ffNum;
        logic [2:0]  ffBits;
        logic [15:0] mask;
    } scanResult_t;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  OUT;
    logic [3:0]  NUM;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [4:0]  ERR_COUNT;
    logic [3:0]  FIRST_FAIL_NUM;
    logic [2:0]  FIRST_FAIL_BITS;
`ifdef INEQ_FAIL_MASK_EN
    logic [15:0] FAIL_MASK;
`endif

    logic        stuckOut0;
    int          checks;
    int          errors;
    int          edgeCount;
    int          startEdge;
    scanResult_t expectQ[$];

    inequality_scanner #(
        .SETTLE (SETTLE)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .START           (START),
        .OUT             (OUT),
        .NUM             (NUM),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .PASS            (PASS),
        .ERR_COUNT       (ERR_COUNT),
        .FIRST_FAIL_NUM  (FIRST_FAIL_NUM),
        .FIRST_FAIL_BITS (FIRST_FAIL_BITS)
`ifdef INEQ_FAIL_MASK_EN
        ,
        .FAIL_MASK       (FAIL_MASK)
`endif
    );

    // Behavioural Inequality: OUT[2] = NUM >= 8, OUT[1] = NUM even,
    // OUT[0] = NUM < 3.
    function automatic logic [2:0] ineqModel(input logic [3:0] n);
        ineqModel = {(n >= 4'd8), (n[0] == 1'b0), (n < 4'd3)};
    endfunction

    assign OUT = ineqModel(NUM) | (stuckOut0 ? 3'b001 : 3'b000);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) edgeCount++;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Predict a complete scan from the model and current fault setting.
    function automatic scanResult_t predictScan(input logic stuck);
        scanResult_t r;
        logic [15:0] g2, g1, g0;
        logic [2:0]  obs, gold, diff;
        g2 = GOLD2;
        g1 = GOLD1;
        g0 = GOLD0;
        r.pass     = 1'b1;
        r.errCount = '0;
        r.ffNum    = '0;
        r.ffBits   = '0;
        r.mask     = '0;
        for (int n = 0; n < 16; n++) begin
            obs  = ineqModel(4'(n)) | (stuck ? 3'b001 : 3'b000);
            gold = {g2[n], g1[n], g0[n]};
            diff = obs ^ gold;
            if (diff != 3'b000) begin
                if (r.pass) begin
                    r.ffNum  = 4'(n);
                    r.ffBits = diff;
                end
                r.pass     = 1'b0;
                r.errCount = r.errCount + 1'b1;
                r.mask[n]  = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Queue the predicted result and drive START for holdCycles edges.
    // Called #1 after a rising edge; returns #1 after the last held edge.
    task automatic applyStimulus(input int holdCycles);
        expectQ.push_back(predictScan(stuckOut0));
        START = 1'b1;
        @(posedge CLK);
        #1;
        startEdge = edgeCount;
        for (int i = 1; i < holdCycles; i++) begin
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
    endtask

    task automatic waitNum(input string tag, input logic [3:0] target);
        for (int i = 0; i < WAIT_BUDGET && NUM !== target; i++) begin
            @(posedge CLK);
            #1;
        end
        checkOutput(tag, NUM, target);
    endtask

    // Wait for DONE, then pop the scoreboard and compare every result.
    task automatic waitDone(input string tag);
        scanResult_t r;
        for (int i = 0; i < WAIT_BUDGET && DONE !== 1'b1; i++) begin
            @(posedge CLK);
            #1;
        end
        checkOutput({tag, "_done"}, DONE, 1);
        if (DONE === 1'b1) begin
            checkOutput({tag, "_latency"}, edgeCount - startEdge, SCAN_EDGES);
        end
        checkOutput({tag, "_queue"}, expectQ.size(), 1);
        if (expectQ.size() > 0) begin
            r = expectQ.pop_front();
            checkOutput({tag, "_pass"}, PASS, r.pass);
            checkOutput({tag, "_errcount"}, ERR_COUNT, r.errCount);
            checkOutput({tag, "_ffnum"}, FIRST_FAIL_NUM, r.ffNum);
            checkOutput({tag, "_ffbits"}, FIRST_FAIL_BITS, r.ffBits);
`ifdef INEQ_FAIL_MASK_EN
            checkOutput({tag, "_mask"}, FAIL_MASK, r.mask);
`endif
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_num"}, NUM, 0);
        checkOutput({tag, "_busy"}, BUSY, 0);
        checkOutput({tag, "_done"}, DONE, 0);
        checkOutput({tag, "_pass"}, PASS, 0);
        checkOutput({tag, "_errcount"}, ERR_COUNT, 0);
        checkOutput({tag, "_ffnum"}, FIRST_FAIL_NUM, 0);
        checkOutput({tag, "_ffbits"}, FIRST_FAIL_BITS, 0);
`ifdef INEQ_FAIL_MASK_EN
        checkOutput({tag, "_mask"}, FAIL_MASK, 0);
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        edgeCount = 0;
        startEdge = 0;
        RESET     = 1'b1;
        START     = 1'b0;
        stuckOut0 = 1'b0;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        checkResetValues("reset");
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checkResetValues("idle");

        // Clean scan with a single-cycle START pulse, plus the NUM=14 spot vector.
        $display("[TB] clean scan");
        applyStimulus(1);
        checkOutput("clean_busy", BUSY, 1);
        waitNum("clean_reach14", 4'd14);
        checkOutput("spot14_out", OUT, 3'b110);
        checkOutput("spot14_err", ERR_COUNT, 0);
        waitNum("clean_reach15", 4'd15);
        checkOutput("spot14_err_after", ERR_COUNT, 0);
        waitDone("clean");
        checkOutput("clean_idle_busy", BUSY, 0);

        // OUT[0] stuck at 1: vectors 3..15 fail.
        $display("[TB] stuck-at-1 on OUT[0]");
        stuckOut0 = 1'b1;
        applyStimulus(1);
        waitDone("stuck");
        checkOutput("stuck_errcount_const", ERR_COUNT, 13);

        // Restart from DONE with the fault removed.
        $display("[TB] restart from done");
        stuckOut0 = 1'b0;
        applyStimulus(1);
        checkOutput("restart_done_drop", DONE, 0);
        checkOutput("restart_busy", BUSY, 1);
        checkOutput("restart_errcount", ERR_COUNT, 0);
        checkOutput("restart_ffnum", FIRST_FAIL_NUM, 0);
        checkOutput("restart_pass", PASS, 0);
        waitDone("restart");

        // Reset in the middle of a failing scan, then rescan.
        $display("[TB] reset mid-scan");
        stuckOut0 = 1'b1;
        applyStimulus(1);
        waitNum("abort_reach7", 4'd7);
        checkOutput("abort_partial_err", ERR_COUNT, 4);
        RESET = 1'b1;
        #1;
        checkResetValues("abort");
        void'(expectQ.pop_back());
        @(posedge CLK);
        #1;
        checkResetValues("abort_hold");
        RESET     = 1'b0;
        stuckOut0 = 1'b0;
        @(posedge CLK);
        #1;
        applyStimulus(1);
        waitDone("rescan");

        // Long START and a re-pulse while busy: exactly one scan.
        $display("[TB] long start and busy re-pulse");
        applyStimulus(5);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("repulse_busy", BUSY, 1);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        waitDone("long_start");
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("long_start_still_done", DONE, 1);
        checkOutput("long_start_num_hold", NUM, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
